// File: rtl/vga_text_engine.sv
// Command sequencer for the VGA text buffer: hardware clear and scroll-up, with host writes always winning the write port.
// Optional build macro VGA_TEXT_STALL_CNT_EN adds stall_cnt_o, a saturating count of engine writes stalled by the host.
//
// state  | meaning
// IDLE   | ready for a command
// CLR    | write fill word to every buffer word
// SC_RD  | present source address (idx + one row)
// SC_LAT | capture read data into hold
// SC_WR  | write hold to idx
// FILL   | write fill word over the vacated bottom row
// DONE   | one-cycle completion pulse
module vga_text_engine #(
   parameter int N_WORDS    = 600,
   parameter int ROW_WORDS  = 20,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 28
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   input  logic [1:0]            cmd_op_i,
   input  logic [6:0]            cmd_fill_i,
   output logic                  cmd_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  host_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_i,
   input  logic [DATA_WIDTH-1:0] host_data_i,
   input  logic [3:0]            host_wstrb_i,
   output logic                  buf_wr_en_o,
   output logic [ADDR_WIDTH-1:0] buf_waddr_o,
   output logic [DATA_WIDTH-1:0] buf_wdata_o,
   output logic [3:0]            buf_wstrb_o,
   output logic [ADDR_WIDTH-1:0] buf_raddr_o,
   input  logic [DATA_WIDTH-1:0] buf_rdata_i
`ifdef VGA_TEXT_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt_o
`endif
);

   typedef enum logic [2:0] {
      IDLE, CLR, SC_RD, SC_LAT, SC_WR, FILL, DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_MV    = ADDR_WIDTH'(N_WORDS - ROW_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] FILL_START = ADDR_WIDTH'(N_WORDS - ROW_WORDS);
   localparam logic [ADDR_WIDTH-1:0] ROW_OFS    = ADDR_WIDTH'(ROW_WORDS);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] idx, idx_nxt;
   logic [DATA_WIDTH-1:0] hold, hold_nxt;
   logic [6:0]            fill_q, fill_nxt;
   logic                  eng_wr;
   logic [DATA_WIDTH-1:0] eng_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         idx    <= '0;
         hold   <= '0;
         fill_q <= '0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         hold   <= hold_nxt;
         fill_q <= fill_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      hold_nxt    = hold;
      fill_nxt    = fill_q;
      cmd_ready_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      buf_raddr_o = '0;
      eng_wr      = 1'b0;
      eng_data    = hold;
      case (state)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               fill_nxt = cmd_fill_i;
               idx_nxt  = '0;
               case (cmd_op_i)
                  2'b01:   state_nxt = CLR;
                  2'b10:   state_nxt = SC_RD;
                  default: state_nxt = DONE;
               endcase
            end
         end
         CLR, FILL: begin
            busy_o   = 1'b1;
            eng_wr   = 1'b1;
            eng_data = {4{fill_q}};
            // a stalled slot is simply retried next cycle with the same idx
            if (!host_wr_en_i) begin
               if (idx == LAST_IDX) state_nxt = DONE;
               else                 idx_nxt   = idx + 1'b1;
            end
         end
         SC_RD: begin
            busy_o      = 1'b1;
            buf_raddr_o = idx + ROW_OFS;
            state_nxt   = SC_LAT;
         end
         SC_LAT: begin
            busy_o    = 1'b1;
            hold_nxt  = buf_rdata_i;
            state_nxt = SC_WR;
         end
         SC_WR: begin
            busy_o = 1'b1;
            eng_wr = 1'b1;
            if (!host_wr_en_i) begin
               if (idx == LAST_MV) begin
                  idx_nxt   = FILL_START;
                  state_nxt = FILL;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = SC_RD;
               end
            end
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      buf_wr_en_o = host_wr_en_i | eng_wr;
      buf_waddr_o = idx;
      buf_wdata_o = eng_data;
      buf_wstrb_o = 4'b1111;
      if (host_wr_en_i) begin
         buf_waddr_o = host_addr_i;
         buf_wdata_o = host_data_i;
         buf_wstrb_o = host_wstrb_i;
      end
   end

`ifdef VGA_TEXT_STALL_CNT_EN
   logic stall;
   assign stall = eng_wr & host_wr_en_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                               stall_cnt_o <= '0;
      else if (cmd_valid_i && cmd_ready_o)     stall_cnt_o <= '0;
      else if (stall && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
   end
`endif

endmodule
